// File: rtl/io_port_unit.sv
// Memory-mapped I/O window: OUT port, synchronized IN port with change flag, and a free-running TIMER.
// The TIMER register is built only when IO_TIMER_EN is defined; otherwise offset 0xC reads 0.
module io_port_unit #(
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [7:0]  PortIn,
  output logic        IOSelect,
  output logic [31:0] IOReadData,
  output logic [31:0] PortOut
);

  logic        hit_s;
  logic [1:0]  offset_s;
  logic        writeEn_s;
  logic        readIn_s;
  logic [31:0] outNext_s;
  logic        changeNext_s;
  logic [31:0] timerValue_s;
  logic        unusedAddr_s;

  logic [31:0] outValue_r;
  logic [7:0]  sync1_r;
  logic [7:0]  sync2_r;
  logic [7:0]  prev_r;
  logic        change_r;

  assign unusedAddr_s = ^Address[1:0];

  // Window decode and per-register strobes
  always_comb begin
    hit_s     = (Address[31:4] == BASE_ADDRESS[31:4]);
    offset_s  = Address[3:2];
    IOSelect  = hit_s & (MemRead | MemWrite);
    writeEn_s = IOSelect & MemWrite;
    readIn_s  = IOSelect & MemRead & (offset_s == 2'd1);
  end

  // Next-state for OUT and the CHANGE flag; a new edge on the synchronized input beats a clearing read
  always_comb begin
    outNext_s = outValue_r;
    if (writeEn_s && (offset_s == 2'd0)) begin
      outNext_s = WriteData;
    end else begin
      outNext_s = outValue_r;
    end
    changeNext_s = change_r;
    if (sync2_r != prev_r) begin
      changeNext_s = 1'b1;
    end else if (readIn_s) begin
      changeNext_s = 1'b0;
    end else begin
      changeNext_s = change_r;
    end
  end

  // OUT register, input synchronizer chain and change detector state
  always_ff @(posedge clk) begin
    if (reset) begin
      outValue_r <= 32'd0;
      sync1_r    <= 8'd0;
      sync2_r    <= 8'd0;
      prev_r     <= 8'd0;
      change_r   <= 1'b0;
    end else begin
      outValue_r <= outNext_s;
      sync1_r    <= PortIn;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      change_r   <= changeNext_s;
    end
  end

`ifdef IO_TIMER_EN
  logic [31:0] timer_r;

  // Free-running counter; a store replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 32'd0;
    end else if (writeEn_s && (offset_s == 2'd3)) begin
      timer_r <= WriteData;
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

  assign timerValue_s = timer_r;
`else
  assign timerValue_s = 32'd0;
`endif

  assign PortOut = outValue_r;

  // Zero-latency load data; shows pre-write contents when a store happens in the same cycle
  always_comb begin
    IOReadData = 32'd0;
    if (IOSelect && MemRead) begin
      case (offset_s)
        2'd0:    IOReadData = outValue_r;
        2'd1:    IOReadData = {24'd0, sync2_r};
        2'd2:    IOReadData = {31'd0, change_r};
        2'd3:    IOReadData = timerValue_s;
        default: IOReadData = 32'd0;
      endcase
    end else begin
      IOReadData = 32'd0;
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed self-checking bench for io_port_unit; expectations follow IO_TIMER_EN when defined.
module tb_io_port_unit;

  localparam logic [31:0] BASE = 32'h1001_0200;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [7:0]  PortIn;
  logic        IOSelect;
  logic [31:0] IOReadData;
  logic [31:0] PortOut;

  int checkCount;
  int passCount;

  io_port_unit #(.BASE_ADDRESS(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .Address(Address),
    .WriteData(WriteData),
    .PortIn(PortIn),
    .IOSelect(IOSelect),
    .IOReadData(IOReadData),
    .PortOut(PortOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = data;
    #1;
  endtask

  task automatic idle();
    setBus(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    setBus(1'b1, 1'b0, addr, 32'd0);
    checkValue(tag, IOReadData, expected);
    idle();
  endtask

  logic [31:0] timerExp[3];
  logic [31:0] timerAfterReset;

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset = 1'b1;
    PortIn = 8'h00;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;

    // reset state
    checkValue("reset_portout", PortOut, 32'd0);
    readCheck("reset_out", BASE, 32'd0);
    readCheck("reset_status", BASE + 32'h8, 32'd0);
    setBus(1'b0, 1'b0, BASE, 32'd0);
    checkValue("no_strobe_select", {31'd0, IOSelect}, 32'd0);
    checkValue("no_strobe_data", IOReadData, 32'd0);
    idle();

    // OUT write and readback
    setBus(1'b0, 1'b1, BASE, 32'hA5A5_0F0F);
    checkValue("store_select", {31'd0, IOSelect}, 32'd1);
    tick();
    idle();
    checkValue("portout_a5", PortOut, 32'hA5A5_0F0F);
    readCheck("load_out", BASE, 32'hA5A5_0F0F);
    readCheck("load_out_bytelane", BASE + 32'h3, 32'hA5A5_0F0F);

    // simultaneous read and write shows old data, write takes effect
    setBus(1'b1, 1'b1, BASE, 32'h1234_5678);
    checkValue("rw_old_data", IOReadData, 32'hA5A5_0F0F);
    tick();
    idle();
    checkValue("rw_portout", PortOut, 32'h1234_5678);

    // input synchronizer and CHANGE flag
    PortIn = 8'h3C;
    tick();
    readCheck("in_edge1", BASE + 32'h4, 32'd0);
    tick();
    readCheck("in_edge2", BASE + 32'h4, 32'h0000_003C);
    readCheck("status_edge2", BASE + 32'h8, 32'd0);
    setBus(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    tick();
    checkValue("status_edge3", IOReadData, 32'd1);
    tick();
    checkValue("status_no_side_effect", IOReadData, 32'd1);
    setBus(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    tick();
    idle();
    readCheck("status_cleared", BASE + 32'h8, 32'd0);

    // clearing read on the same edge as a new change: set wins
    PortIn = 8'h3D;
    tick();
    tick();
    readCheck("in_3d", BASE + 32'h4, 32'h0000_003D);
    setBus(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    tick();
    idle();
    readCheck("status_set_wins", BASE + 32'h8, 32'd1);
    setBus(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    tick();
    idle();
    readCheck("status_cleared2", BASE + 32'h8, 32'd0);

    // misses and read-only registers
    setBus(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
    checkValue("miss_select", {31'd0, IOSelect}, 32'd0);
    tick();
    idle();
    checkValue("miss_portout", PortOut, 32'h1234_5678);
    setBus(1'b1, 1'b0, BASE + 32'h10, 32'd0);
    checkValue("miss_load_data", IOReadData, 32'd0);
    checkValue("miss_load_select", {31'd0, IOSelect}, 32'd0);
    idle();
    setBus(1'b0, 1'b1, BASE + 32'h4, 32'h0000_00FF);
    tick();
    setBus(1'b0, 1'b1, BASE + 32'h8, 32'h0000_0001);
    tick();
    idle();
    checkValue("ro_portout", PortOut, 32'h1234_5678);
    readCheck("ro_in", BASE + 32'h4, 32'h0000_003D);
    readCheck("ro_status", BASE + 32'h8, 32'd0);

    // TIMER wrap
`ifdef IO_TIMER_EN
    timerExp[0] = 32'hFFFF_FFFF;
    timerExp[1] = 32'h0000_0000;
    timerExp[2] = 32'h0000_0001;
    timerAfterReset = 32'd1;
`else
    timerExp[0] = 32'd0;
    timerExp[1] = 32'd0;
    timerExp[2] = 32'd0;
    timerAfterReset = 32'd0;
`endif
    setBus(1'b0, 1'b1, BASE + 32'hC, 32'hFFFF_FFFE);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      readCheck($sformatf("timer_%0d", i), BASE + 32'hC, timerExp[i]);
    end

    // reset beats a same-cycle store
    setBus(1'b0, 1'b1, BASE, 32'h0000_0055);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    checkValue("reset_store_portout", PortOut, 32'd0);
    readCheck("reset_timer0", BASE + 32'hC, 32'd0);
    readCheck("reset_in", BASE + 32'h4, 32'd0);
    tick();
    readCheck("reset_timer1", BASE + 32'hC, timerAfterReset);
    readCheck("reset_status_first", BASE + 32'h8, 32'd0);
    checkValue("reset_portout_hold", PortOut, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
